phase_detector: RTL and testbench

- Measures the phase between the transducer voltage and current zero-crossings, once per drive period.
- Produces the signed 9-bit phase word and the per-period sample strobe that clock the downstream phase-tracking controller.
- Sits between the analog zero-cross comparators and the controller's phase/strobe inputs.
- Unit of phase is one clk cycle.

---
 rtl/phase_detector.sv | 215 +++++++++++++++++++++
 tb/tb_phase_detector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_detector.sv
// phase_detector: measures the voltage-to-current zero-crossing phase once per drive period.
// Define DEGLITCH_EN to insert a 3-sample majority filter after each input synchronizer.
module phase_detector #(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 4000,
  parameter int PH_MAX  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_zc,
  input  logic              i_zc,
  input  logic              standby,
  output logic signed [8:0] phase,
  output logic              sample_pulse,
  output logic [CNT_W-1:0]  period,
  output logic              no_signal
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [CNT_W:0]          TIMEOUT_C = (CNT_W+1)'(TIMEOUT);
  localparam logic signed [CNT_W+1:0] PH_HI     = (CNT_W+2)'(PH_MAX);
  localparam logic signed [CNT_W+1:0] PH_LO     = -PH_HI;

  logic [1:0] zc_in;
  logic [1:0] edge_rise;

  assign zc_in = {i_zc, v_zc};

  // Channel 0 is voltage, channel 1 is current; both paths are identical so their latencies cancel.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic meta_q;
      logic sync_q;
      logic prev_q;
      logic rise_q;
      logic filt;

      // Sync flops reset high so a comparator already high at release is not seen as an edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          meta_q <= 1'b1;
          sync_q <= 1'b1;
        end else begin
          meta_q <= zc_in[gi];
          sync_q <= meta_q;
        end
      end

`ifdef DEGLITCH_EN
      logic [1:0] hist_q;
      logic       maj_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          hist_q <= 2'b11;
          maj_q  <= 1'b1;
        end else begin
          hist_q <= {hist_q[0], sync_q};
          maj_q  <= (sync_q & hist_q[0]) | (sync_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
        end
      end

      assign filt = maj_q;
`else
      assign filt = sync_q;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          prev_q <= 1'b1;
          rise_q <= 1'b0;
        end else begin
          prev_q <= filt;
          rise_q <= filt & ~prev_q;
        end
      end

      assign edge_rise[gi] = rise_q;
    end
  endgenerate

  logic                    v_rise;
  logic                    i_rise;
  logic                    clr;
  logic [1:0]              state_q,  state_d;
  logic [CNT_W-1:0]        cnt_v_q,  cnt_v_d;
  logic [CNT_W-1:0]        cnt_i_q,  cnt_i_d;
  logic                    i_seen_q, i_seen_d;
  logic [CNT_W-1:0]        period_q, period_d;
  logic signed [8:0]       phase_q,  phase_d;
  logic                    fire_q,   fire_d;
  logic                    pulse_q;
  logic                    no_signal_q, no_signal_d;

  logic [CNT_W:0]          cnt_next;
  logic [CNT_W-1:0]        meas_period;
  logic signed [CNT_W+1:0] raw;
  logic signed [CNT_W+1:0] raw_sat;

  assign v_rise = edge_rise[0];
  assign i_rise = edge_rise[1];
  assign clr    = rst | standby;

  // cnt_v holds (cycles since v_rise) - 1, so the live count of the current cycle is cnt_v + 1.
  always_comb begin
    cnt_next    = {1'b0, cnt_v_q} + (CNT_W+1)'(1);
    meas_period = cnt_next[CNT_W-1:0];

    if (cnt_i_q < (meas_period >> 1)) begin
      raw = signed'({2'b00, cnt_i_q});
    end else begin
      raw = signed'({2'b00, cnt_i_q}) - signed'({2'b00, meas_period});
    end

    if (raw > PH_HI) begin
      raw_sat = PH_HI;
    end else if (raw < PH_LO) begin
      raw_sat = PH_LO;
    end else begin
      raw_sat = raw;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_v_d     = cnt_v_q;
    cnt_i_d     = cnt_i_q;
    i_seen_d    = i_seen_q;
    period_d    = period_q;
    phase_d     = phase_q;
    fire_d      = 1'b0;
    no_signal_d = no_signal_q;

    case (state_q)
      IDLE: begin
        if (v_rise) begin
          state_d  = ARM;
          cnt_v_d  = '0;
          cnt_i_d  = '0;
          i_seen_d = i_rise;
        end
      end

      ARM, RUN: begin
        if (v_rise) begin
          // Close the period; a coincident i_rise belongs to the new period at count 0.
          state_d  = RUN;
          period_d = meas_period;
          cnt_v_d  = '0;
          cnt_i_d  = '0;
          i_seen_d = i_rise;
          if (i_seen_q) begin
            phase_d = 9'(raw_sat);
            fire_d  = 1'b1;
          end
        end else if (cnt_next >= TIMEOUT_C) begin
          state_d     = IDLE;
          cnt_v_d     = '0;
          cnt_i_d     = '0;
          i_seen_d    = 1'b0;
          phase_d     = '0;
          no_signal_d = 1'b1;
        end else begin
          cnt_v_d = meas_period;
          if (i_rise && !i_seen_q) begin
            cnt_i_d  = meas_period;
            i_seen_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (fire_q) begin
      no_signal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      cnt_v_q     <= '0;
      cnt_i_q     <= '0;
      i_seen_q    <= 1'b0;
      period_q    <= '0;
      phase_q     <= '0;
      fire_q      <= 1'b0;
      pulse_q     <= 1'b0;
      no_signal_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_v_q     <= cnt_v_d;
      cnt_i_q     <= cnt_i_d;
      i_seen_q    <= i_seen_d;
      period_q    <= period_d;
      phase_q     <= phase_d;
      fire_q      <= fire_d;
      pulse_q     <= fire_q;
      no_signal_q <= no_signal_d;
    end
  end

  assign phase        = phase_q;
  assign sample_pulse = pulse_q;
  assign period       = period_q;
  assign no_signal    = no_signal_q;

endmodule

// File: tb/tb_phase_detector.sv
// Testbench for phase_detector: square-wave stimulus checked against an arithmetic phase model.
module tb_phase_detector;

  localparam int CNT_W   = 12;
  localparam int TIMEOUT = 4000;
  localparam int PH_MAX  = 255;
`ifdef DEGLITCH_EN
  localparam int LAT       = 5;
  localparam int GLITCH_PH = 100;
`else
  localparam int LAT       = 3;
  localparam int GLITCH_PH = 20;
`endif

  logic              clk     = 1'b0;
  logic              rst     = 1'b1;
  logic              v_zc    = 1'b0;
  logic              i_zc    = 1'b0;
  logic              standby = 1'b0;
  logic signed [8:0] phase;
  logic              sample_pulse;
  logic [CNT_W-1:0]  period;
  logic              no_signal;

  int total = 0;
  int bad   = 0;

  int wave_t = 0;
  int pulse_ph[$];
  logic signed [8:0] obs_phase;
  logic              obs_pulse;
  logic [CNT_W-1:0]  obs_period;
  logic              obs_ns;
  int                obs_t;

  always #5 clk = ~clk;

  phase_detector #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .PH_MAX(PH_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .v_zc         (v_zc),
    .i_zc         (i_zc),
    .standby      (standby),
    .phase        (phase),
    .sample_pulse (sample_pulse),
    .period       (period),
    .no_signal    (no_signal)
  );

  // Expected phase for current lagging voltage by lag cycles.
  function automatic int ref_phase(input int per, input int lag);
    int l;
    int raw;
    l   = lag % per;
    raw = (l < per / 2) ? l : l - per;
    if (raw > PH_MAX)  raw = PH_MAX;
    if (raw < -PH_MAX) raw = -PH_MAX;
    return raw;
  endfunction

  // Drives ncyc cycles of the waveform; samples outputs on the falling edge first.
  task automatic drive(input int per, input int lag, input int ncyc, input int glitch, input bit v_en);
    for (int n = 0; n < ncyc; n++) begin
      int ph;
      int ip;
      @(negedge clk);
      obs_phase  = phase;
      obs_pulse  = sample_pulse;
      obs_period = period;
      obs_ns     = no_signal;
      obs_t      = wave_t;
      if (sample_pulse) pulse_ph.push_back(int'(phase));
      ph   = wave_t % per;
      ip   = (ph - (lag % per) + per) % per;
      v_zc = v_en && (ph < per / 2);
      i_zc = v_en && ((ip < per / 2) || (ph == glitch));
      wave_t++;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    standby = 1'b0;
    v_zc    = 1'b0;
    i_zc    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    wave_t = 0;
    pulse_ph.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (phase !== 9'sd0) begin bad++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    total++; if (sample_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %0b expected 0", sample_pulse); end
    total++; if (period !== '0) begin bad++; $display("FAIL reset_period: got %0d expected 0", period); end
    total++; if (no_signal !== 1'b1) begin bad++; $display("FAIL reset_no_signal: got %0b expected 1", no_signal); end
    $display("reset: phase=%0d pulse=%0b period=%0d no_signal=%0b", phase, sample_pulse, period, no_signal);
  endtask

  task automatic test_lock();
    do_reset();
    drive(600, 100, 600, -1, 1'b1);
    total++; if (pulse_ph.size() != 0) begin bad++; $display("FAIL lock_first_edge: got %0d strobes expected 0", pulse_ph.size()); end
    total++; if (obs_ns !== 1'b1) begin bad++; $display("FAIL lock_ns_before: got %0b expected 1", obs_ns); end
    drive(600, 100, 20, -1, 1'b1);
    total++; if (pulse_ph.size() != 1) begin bad++; $display("FAIL lock_second_edge: got %0d strobes expected 1", pulse_ph.size()); end
    drive(600, 100, 2380, -1, 1'b1);
    total++; if (pulse_ph.size() != 4) begin bad++; $display("FAIL lock_strobes: got %0d expected 4", pulse_ph.size()); end
    total++; if (obs_period !== 12'd600) begin bad++; $display("FAIL lock_period: got %0d expected 600", obs_period); end
    total++; if (obs_ns !== 1'b0) begin bad++; $display("FAIL lock_no_signal: got %0b expected 0", obs_ns); end
    foreach (pulse_ph[k]) begin
      total++; if (pulse_ph[k] != 100) begin bad++; $display("FAIL lock_phase[%0d]: got %0d expected 100", k, pulse_ph[k]); end
    end
    $display("lock: per=600 lag=100 strobes=%0d period=%0d", pulse_ph.size(), obs_period);
  endtask

  task automatic test_steady(input int per, input int lag, input string name);
    int exp_ph;
    exp_ph = ref_phase(per, lag);
    do_reset();
    drive(per, lag, 2 * per, -1, 1'b1);
    pulse_ph.delete();
    drive(per, lag, 3 * per, -1, 1'b1);
    total++; if (pulse_ph.size() != 3) begin bad++; $display("FAIL %s_strobes: got %0d expected 3", name, pulse_ph.size()); end
    total++; if (int'(obs_period) != per) begin bad++; $display("FAIL %s_period: got %0d expected %0d", name, obs_period, per); end
    total++; if (obs_ns !== 1'b0) begin bad++; $display("FAIL %s_no_signal: got %0b expected 0", name, obs_ns); end
    foreach (pulse_ph[k]) begin
      total++; if (pulse_ph[k] != exp_ph) begin bad++; $display("FAIL %s_phase[%0d]: got %0d expected %0d", name, k, pulse_ph[k], exp_ph); end
    end
    $display("%s: per=%0d lag=%0d expected_phase=%0d strobes=%0d", name, per, lag, exp_ph, pulse_ph.size());
  endtask

  task automatic test_timeout();
    int seen;
    do_reset();
    drive(600, 100, 2100, -1, 1'b1);
    pulse_ph.delete();
    seen = -1;
    for (int k = 0; k < 6000; k++) begin
      drive(600, 100, 1, -1, 1'b0);
      if (obs_ns === 1'b1) begin
        seen = obs_t;
        break;
      end
    end
    // Last voltage edge was driven at wave_t = 1800.
    total++; if (seen - 1800 != LAT + TIMEOUT + 1) begin bad++; $display("FAIL timeout_delay: got %0d expected %0d", seen - 1800, LAT + TIMEOUT + 1); end
    total++; if (obs_phase !== 9'sd0) begin bad++; $display("FAIL timeout_phase: got %0d expected 0", obs_phase); end
    total++; if (pulse_ph.size() != 0) begin bad++; $display("FAIL timeout_strobes: got %0d expected 0", pulse_ph.size()); end
    wave_t = 0;
    drive(600, 100, 600, -1, 1'b1);
    total++; if (pulse_ph.size() != 0) begin bad++; $display("FAIL restart_first_edge: got %0d strobes expected 0", pulse_ph.size()); end
    total++; if (obs_ns !== 1'b1) begin bad++; $display("FAIL restart_ns_before: got %0b expected 1", obs_ns); end
    drive(600, 100, 20, -1, 1'b1);
    total++; if (pulse_ph.size() != 1) begin bad++; $display("FAIL restart_strobe: got %0d expected 1", pulse_ph.size()); end
    else begin
      total++; if (pulse_ph[0] != 100) begin bad++; $display("FAIL restart_phase: got %0d expected 100", pulse_ph[0]); end
    end
    total++; if (obs_ns !== 1'b0) begin bad++; $display("FAIL restart_no_signal: got %0b expected 0", obs_ns); end
    $display("timeout: delay=%0d restart_strobes=%0d", seen - 1800, pulse_ph.size());
  endtask

  task automatic test_midreset();
    do_reset();
    drive(600, 100, 2100, -1, 1'b1);
    pulse_ph.delete();
    rst = 1'b1;
    drive(600, 100, 1, -1, 1'b1);
    rst = 1'b0;
    total++; if (obs_phase !== 9'sd0) begin bad++; $display("FAIL midrst_phase: got %0d expected 0", obs_phase); end
    total++; if (obs_pulse !== 1'b0) begin bad++; $display("FAIL midrst_pulse: got %0b expected 0", obs_pulse); end
    total++; if (obs_period !== '0) begin bad++; $display("FAIL midrst_period: got %0d expected 0", obs_period); end
    total++; if (obs_ns !== 1'b1) begin bad++; $display("FAIL midrst_no_signal: got %0b expected 1", obs_ns); end
    drive(600, 100, 3000 - wave_t, -1, 1'b1);
    total++; if (pulse_ph.size() != 0) begin bad++; $display("FAIL midrst_early_strobe: got %0d expected 0", pulse_ph.size()); end
    drive(600, 100, 20, -1, 1'b1);
    total++; if (pulse_ph.size() != 1) begin bad++; $display("FAIL midrst_strobe: got %0d expected 1", pulse_ph.size()); end
    else begin
      total++; if (pulse_ph[0] != 100) begin bad++; $display("FAIL midrst_phase_after: got %0d expected 100", pulse_ph[0]); end
    end
    $display("midreset: strobes_after=%0d", pulse_ph.size());
  endtask

  task automatic test_standby();
    do_reset();
    drive(600, 100, 2100, -1, 1'b1);
    pulse_ph.delete();
    standby = 1'b1;
    drive(600, 100, 1250, -1, 1'b1);
    total++; if (obs_ns !== 1'b1) begin bad++; $display("FAIL standby_no_signal: got %0b expected 1", obs_ns); end
    total++; if (obs_period !== '0) begin bad++; $display("FAIL standby_period: got %0d expected 0", obs_period); end
    total++; if (pulse_ph.size() != 0) begin bad++; $display("FAIL standby_strobes: got %0d expected 0", pulse_ph.size()); end
    standby = 1'b0;
    drive(600, 100, 4220 - wave_t, -1, 1'b1);
    total++; if (pulse_ph.size() != 1) begin bad++; $display("FAIL standby_release: got %0d strobes expected 1", pulse_ph.size()); end
    $display("standby: strobes_after_release=%0d", pulse_ph.size());
  endtask

  task automatic test_glitch();
    do_reset();
    drive(600, 100, 1200, 20, 1'b1);
    pulse_ph.delete();
    drive(600, 100, 1800, 20, 1'b1);
    total++; if (pulse_ph.size() != 3) begin bad++; $display("FAIL glitch_strobes: got %0d expected 3", pulse_ph.size()); end
    foreach (pulse_ph[k]) begin
      total++; if (pulse_ph[k] != GLITCH_PH) begin bad++; $display("FAIL glitch_phase[%0d]: got %0d expected %0d", k, pulse_ph[k], GLITCH_PH); end
    end
    $display("glitch: expected_phase=%0d strobes=%0d", GLITCH_PH, pulse_ph.size());
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int per;
      int lag;
      per = int'($urandom_range(100, 1000));
      lag = int'($urandom_range(0, per - 1));
      test_steady(per, lag, "random");
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_steady(600, 550, "lead");
    test_steady(1000, 400, "sat_pos");
    test_steady(1000, 500, "sat_half");
    test_timeout();
    test_midreset();
    test_standby();
    test_glitch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
